// File: rtl/tpu_pkg.sv
// Shared constants, FSM state encoding and tile-count helper for the TPU tile scheduler.
package tpu_pkg;

   localparam int unsigned ARRAY_SIZE = 4;
   localparam int unsigned DIM_W      = 4;
   localparam int unsigned ADDR_W     = 16;
   localparam int unsigned ROW_SEL_W  = $clog2(ARRAY_SIZE);
   localparam int unsigned PH_W       = $clog2(2 * ARRAY_SIZE);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      FEED  = 3'd2,
      FLUSH = 3'd3,
      WRITE = 3'd4,
      DONE  = 3'd5
   } state_e;

   // Number of ARRAY_SIZE-wide tiles needed to cover x; one extra bit avoids overflow.
   function automatic logic [DIM_W-1:0] ceil_div(input logic [DIM_W-1:0] x);
      logic [DIM_W:0] sum;
      sum = (DIM_W+1)'(x) + (DIM_W+1)'(ARRAY_SIZE - 1);
      return DIM_W'(sum / (DIM_W+1)'(ARRAY_SIZE));
   endfunction

endpackage

// File: rtl/tpu_tile_counter.sv
// Nested row/column output-tile counter: column inner, row outer, with wrap and last-tile flag.
module tpu_tile_counter
   import tpu_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear_i,
   input  logic             advance_i,
   input  logic [DIM_W-1:0] row_tiles_i,
   input  logic [DIM_W-1:0] col_tiles_i,
   output logic [DIM_W-1:0] row_tile_o,
   output logic [DIM_W-1:0] col_tile_o,
   output logic             last_c_o
);

   logic [DIM_W-1:0] row_q, row_d;
   logic [DIM_W-1:0] col_q, col_d;
   logic             col_wrap_c;
   logic             row_wrap_c;

   always_comb begin
      col_wrap_c = (col_q == col_tiles_i - DIM_W'(1));
      row_wrap_c = (row_q == row_tiles_i - DIM_W'(1));
      row_d      = row_q;
      col_d      = col_q;
      if (clear_i) begin
         row_d = '0;
         col_d = '0;
      end else if (advance_i) begin
         if (col_wrap_c) begin
            col_d = '0;
            row_d = row_wrap_c ? '0 : row_q + DIM_W'(1);
         end else begin
            col_d = col_q + DIM_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

   assign row_tile_o = row_q;
   assign col_tile_o = col_q;
   assign last_c_o   = col_wrap_c && row_wrap_c;

endmodule

// File: rtl/tpu_tile_scheduler.sv
// Tile sequencer for C = A*B on the systolic array: read feed, flush, row-wise write-back.
// Optional perf counters (cycle_cnt, out_wr_cnt) are built when TPU_PERF_CNT_EN is defined.
module tpu_tile_scheduler
   import tpu_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [DIM_W-1:0]     m,
   input  logic [DIM_W-1:0]     k,
   input  logic [DIM_W-1:0]     n,
   output logic                 a_rd_en,
   output logic [ADDR_W-1:0]    a_addr,
   output logic                 b_rd_en,
   output logic [ADDR_W-1:0]    b_addr,
   output logic                 pe_clear,
   output logic                 feed_valid,
   output logic                 out_we,
   output logic [ADDR_W-1:0]    out_addr,
   output logic [ROW_SEL_W-1:0] out_row_sel,
   output logic                 busy,
`ifdef TPU_PERF_CNT_EN
   output logic [31:0]          cycle_cnt,
   output logic [15:0]          out_wr_cnt,
`endif
   output logic                 done
);

   state_e           state_q;
   logic [DIM_W-1:0] m_q, k_q;
   logic [DIM_W-1:0] row_tiles_q, col_tiles_q;
   logic [DIM_W-1:0] t_q;
   logic [PH_W-1:0]  ph_q;

   logic [DIM_W-1:0]  row_tile, col_tile;
   logic              last_tile_c;
   logic              start_ok_c, zero_dim_c, tile_end_c, busy_st_c, wr_en_c;
   logic [ADDR_W-1:0] row_c;

   always_comb begin
      start_ok_c = start && ((state_q == IDLE) || (state_q == DONE));
      zero_dim_c = (m == '0) || (k == '0) || (n == '0);
      tile_end_c = (state_q == WRITE) && (ph_q == PH_W'(ARRAY_SIZE - 1));
      busy_st_c  = (state_q != IDLE) && (state_q != DONE);
      row_c      = ADDR_W'(row_tile) * ADDR_W'(ARRAY_SIZE) + ADDR_W'(ph_q);
      wr_en_c    = (state_q == WRITE) && (row_c < ADDR_W'(m_q));
   end

   tpu_tile_counter u_tile_counter (
      .clk         (clk),
      .rst         (rst),
      .clear_i     (start_ok_c),
      .advance_i   (tile_end_c),
      .row_tiles_i (row_tiles_q),
      .col_tiles_i (col_tiles_q),
      .row_tile_o  (row_tile),
      .col_tile_o  (col_tile),
      .last_c_o    (last_tile_c)
   );

   // Outputs are registered from the current state, so they trail the state by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         m_q         <= '0;
         k_q         <= '0;
         row_tiles_q <= '0;
         col_tiles_q <= '0;
         t_q         <= '0;
         ph_q        <= '0;
         a_rd_en     <= 1'b0;
         a_addr      <= '0;
         b_rd_en     <= 1'b0;
         b_addr      <= '0;
         pe_clear    <= 1'b0;
         feed_valid  <= 1'b0;
         out_we      <= 1'b0;
         out_addr    <= '0;
         out_row_sel <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         pe_clear    <= (state_q == CLEAR);
         a_rd_en     <= (state_q == FEED);
         b_rd_en     <= (state_q == FEED);
         a_addr      <= (state_q == FEED) ?
                        ADDR_W'(row_tile) * ADDR_W'(k_q) + ADDR_W'(t_q) : '0;
         b_addr      <= (state_q == FEED) ?
                        ADDR_W'(col_tile) * ADDR_W'(k_q) + ADDR_W'(t_q) : '0;
         feed_valid  <= a_rd_en;
         out_we      <= wr_en_c;
         out_addr    <= (state_q == WRITE) ?
                        row_c * ADDR_W'(col_tiles_q) + ADDR_W'(col_tile) : '0;
         out_row_sel <= (state_q == WRITE) ? ROW_SEL_W'(ph_q) : '0;
         busy        <= busy_st_c;
         done        <= (state_q == DONE);

         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  m_q         <= m;
                  k_q         <= k;
                  row_tiles_q <= ceil_div(m);
                  col_tiles_q <= ceil_div(n);
                  t_q         <= '0;
                  ph_q        <= '0;
                  state_q     <= zero_dim_c ? DONE : CLEAR;
               end
            end
            CLEAR: begin
               t_q     <= '0;
               state_q <= FEED;
            end
            FEED: begin
               if (t_q == k_q - DIM_W'(1)) begin
                  t_q     <= '0;
                  ph_q    <= '0;
                  state_q <= FLUSH;
               end else begin
                  t_q <= t_q + DIM_W'(1);
               end
            end
            // Wait out the array skew and drain before reading results.
            FLUSH: begin
               if (ph_q == PH_W'(2 * ARRAY_SIZE - 2)) begin
                  ph_q    <= '0;
                  state_q <= WRITE;
               end else begin
                  ph_q <= ph_q + PH_W'(1);
               end
            end
            WRITE: begin
               if (tile_end_c) begin
                  ph_q    <= '0;
                  state_q <= last_tile_c ? DONE : CLEAR;
               end else begin
                  ph_q <= ph_q + PH_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef TPU_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cycle_cnt  <= '0;
         out_wr_cnt <= '0;
      end else if (start_ok_c) begin
         cycle_cnt  <= '0;
         out_wr_cnt <= '0;
      end else begin
         if (busy_st_c) cycle_cnt  <= cycle_cnt + 32'd1;
         if (wr_en_c)   out_wr_cnt <= out_wr_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_tpu_tile_scheduler.sv
// Scoreboard bench for tpu_tile_scheduler: a job-level model queues expected reads/writes/timing.
module tb_tpu_tile_scheduler;
   import tpu_pkg::*;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic [DIM_W-1:0]     m, k, n;
   logic                 a_rd_en, b_rd_en, pe_clear, feed_valid, out_we, busy, done;
   logic [ADDR_W-1:0]    a_addr, b_addr, out_addr;
   logic [ROW_SEL_W-1:0] out_row_sel;
`ifdef TPU_PERF_CNT_EN
   logic [31:0]          cycle_cnt;
   logic [15:0]          out_wr_cnt;
`endif

   tpu_tile_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .m           (m),
      .k           (k),
      .n           (n),
      .a_rd_en     (a_rd_en),
      .a_addr      (a_addr),
      .b_rd_en     (b_rd_en),
      .b_addr      (b_addr),
      .pe_clear    (pe_clear),
      .feed_valid  (feed_valid),
      .out_we      (out_we),
      .out_addr    (out_addr),
      .out_row_sel (out_row_sel),
      .busy        (busy),
`ifdef TPU_PERF_CNT_EN
      .cycle_cnt   (cycle_cnt),
      .out_wr_cnt  (out_wr_cnt),
`endif
      .done        (done)
   );

   always #5 clk = ~clk;

   typedef struct { int cyc; int a; int b; } rd_t;
   typedef struct { int cyc; int addr; int sel; } wr_t;

   rd_t rd_q[$];
   wr_t wr_q[$];
   int  clr_q[$];
   int  fv_q[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int start_cyc = 0;
   int exp_lat = 0;
   int exp_wr_cnt = 0;
   bit mon_en = 0;
   bit done_prev = 0;
   bit done_seen = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Job-level reference: every tile takes k + 3*ARRAY_SIZE cycles, events at fixed offsets.
   task automatic model_job(input int mm, input int kk, input int nn);
      int rt, ct, tp, tile, base, row;
      rt = (mm + 3) / 4;
      ct = (nn + 3) / 4;
      exp_wr_cnt = 0;
      if (mm == 0 || kk == 0 || nn == 0) begin
         exp_lat = 1;
         return;
      end
      tp = kk + 12;
      tile = 0;
      for (int r = 0; r < rt; r++) begin
         for (int c = 0; c < ct; c++) begin
            base = tile * tp;
            clr_q.push_back(base + 1);
            for (int t = 0; t < kk; t++) begin
               rd_q.push_back('{cyc: base + 2 + t, a: r * kk + t, b: c * kk + t});
               fv_q.push_back(base + 3 + t);
            end
            for (int j = 0; j < 4; j++) begin
               row = r * 4 + j;
               if (row < mm) begin
                  wr_q.push_back('{cyc: base + kk + 9 + j, addr: row * ct + c, sel: j});
                  exp_wr_cnt++;
               end
            end
            tile++;
         end
      end
      exp_lat = rt * ct * tp + 1;
   endtask

   always @(negedge clk) begin : monitor
      int rel;
      rd_t r;
      wr_t w;
      int  c;
      rel = cyc - start_cyc;
      if (rst) begin
         done_prev = 1'b0;
      end else if (mon_en) begin
         if (a_rd_en || b_rd_en) begin
            if (rd_q.size() == 0) check("rd_pending", 32'(rd_q.size()), 32'd1);
            else begin
               r = rd_q.pop_front();
               check("rd_cycle", 32'(rel), 32'(r.cyc));
               check("a_addr", 32'(a_addr), 32'(r.a));
               check("b_addr", 32'(b_addr), 32'(r.b));
               check("rd_en_pair", 32'(a_rd_en & b_rd_en), 32'd1);
            end
         end
         if (feed_valid) begin
            if (fv_q.size() == 0) check("fv_pending", 32'(fv_q.size()), 32'd1);
            else begin
               c = fv_q.pop_front();
               check("feed_valid_cycle", 32'(rel), 32'(c));
            end
         end
         if (pe_clear) begin
            if (clr_q.size() == 0) check("clr_pending", 32'(clr_q.size()), 32'd1);
            else begin
               c = clr_q.pop_front();
               check("pe_clear_cycle", 32'(rel), 32'(c));
               check("busy_at_clear", 32'(busy), 32'd1);
            end
         end
         if (out_we) begin
            if (wr_q.size() == 0) check("wr_pending", 32'(wr_q.size()), 32'd1);
            else begin
               w = wr_q.pop_front();
               check("wr_cycle", 32'(rel), 32'(w.cyc));
               check("out_addr", 32'(out_addr), 32'(w.addr));
               check("out_row_sel", 32'(out_row_sel), 32'(w.sel));
            end
         end
         if (done && !done_prev) begin
            check("done_latency", 32'(rel), 32'(exp_lat));
            check("busy_at_done", 32'(busy), 32'd0);
`ifdef TPU_PERF_CNT_EN
            check("cycle_cnt", cycle_cnt, 32'(exp_lat - 1));
            check("out_wr_cnt", 32'(out_wr_cnt), 32'(exp_wr_cnt));
`endif
            done_seen = 1'b1;
         end
         done_prev = done;
      end
   end

   task automatic launch(input int mm, input int kk, input int nn);
      bit prev_done;
      @(negedge clk);
      prev_done = done;
      model_job(mm, kk, nn);
      done_seen = 1'b0;
      m = DIM_W'(mm);
      k = DIM_W'(kk);
      n = DIM_W'(nn);
      start = 1'b1;
      @(posedge clk);
      #1 start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
      if (prev_done) begin
         @(negedge clk);
         check("done_drop", 32'(done), 32'd0);
      end
   endtask

   task automatic wait_done();
      int i;
      i = 0;
      while (!done_seen && i < exp_lat + 10) begin
         @(posedge clk);
         i++;
      end
      check("done_seen", 32'(done_seen), 32'd1);
      check("rd_left", 32'(rd_q.size()), 32'd0);
      check("wr_left", 32'(wr_q.size()), 32'd0);
      check("clr_left", 32'(clr_q.size()), 32'd0);
      check("fv_left", 32'(fv_q.size()), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_a_rd_en"}, 32'(a_rd_en), 32'd0);
      check({tag, "_b_rd_en"}, 32'(b_rd_en), 32'd0);
      check({tag, "_a_addr"}, 32'(a_addr), 32'd0);
      check({tag, "_b_addr"}, 32'(b_addr), 32'd0);
      check({tag, "_pe_clear"}, 32'(pe_clear), 32'd0);
      check({tag, "_feed_valid"}, 32'(feed_valid), 32'd0);
      check({tag, "_out_we"}, 32'(out_we), 32'd0);
      check({tag, "_out_addr"}, 32'(out_addr), 32'd0);
      check({tag, "_out_row_sel"}, 32'(out_row_sel), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_state"}, 32'(dut.state_q), 32'(IDLE));
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      m = '0;
      k = '0;
      n = '0;
      #1;
      check_all_zero("reset");
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      mon_en = 1'b1;
      repeat (2) @(negedge clk);

      // Zero dimension: immediate done, no traffic.
      launch(0, 4, 4);
      wait_done();

      // Single tile, started from DONE.
      launch(4, 4, 4);
      wait_done();

      // Six tiles with partial last row tile; start and m poked while busy.
      launch(6, 3, 9);
      repeat (20) @(negedge clk);
      m = 4'd1;
      k = 4'd7;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      start = 1'b1;
      n = 4'd2;
      @(negedge clk);
      start = 1'b0;
      wait_done();

      // Reset during FEED of tile 2, then a clean rerun of the same job.
      launch(8, 5, 8);
      while (cyc - start_cyc < 37) begin
         @(posedge clk);
         #1;
      end
      check("rd_before_reset", 32'(a_rd_en), 32'd1);
      #1 rst = 1'b1;
      #1;
      check_all_zero("midjob_reset");
      rd_q.delete();
      wr_q.delete();
      clr_q.delete();
      fv_q.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      launch(8, 5, 8);
      wait_done();

      // Randomized jobs back to back from DONE.
      for (int i = 0; i < 12; i++) begin
         launch(int'($urandom_range(1, 15)), int'($urandom_range(1, 15)),
                int'($urandom_range(1, 15)));
         wait_done();
      end

      launch(4, 4, 4);
      wait_done();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tpu_tile_scheduler.md
Name: tpu_tile_scheduler

Overview:
- Top-level sequencer for the TPU matrix-multiply path: computes C[m x n] = A[m x k] * B[k x n] on the ARRAY_SIZE x ARRAY_SIZE systolic array.
- Latches m/k/n on start and walks output tiles in order: row tile outer, column tile inner.
- Per tile: issues GBUFF_A/GBUFF_B read addresses, clears PE accumulators, waits out the skew/drain, then drives GBUFF_OUT writes one row at a time.
- Sits between top-level start/done and the global buffers plus PE array.

Parameters:
ARRAY_SIZE, 4, systolic array dimension; also the number of output bytes per GBUFF_OUT word.
DIM_W, 4, width of m/k/n; legal value range is 0..2^DIM_W-1.
ADDR_W, 16, global buffer address width (GBUFF_ADDR_SIZE).

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  begin a job; sampled only in IDLE or DONE.
m  in  DIM_W  rows of A.
k  in  DIM_W  inner dimension.
n  in  DIM_W  columns of B.
a_rd_en  out  1  GBUFF_A read enable.
a_addr  out  ADDR_W  GBUFF_A address = row_tile*k + t.
b_rd_en  out  1  GBUFF_B read enable.
b_addr  out  ADDR_W  GBUFF_B address = col_tile*k + t.
pe_clear  out  1  one-cycle accumulator clear for the array.
feed_valid  out  1  buffer read data valid at the array inputs (a_rd_en delayed one cycle).
out_we  out  1  GBUFF_OUT write enable.
out_addr  out  ADDR_W  GBUFF_OUT address = row*col_tiles + col_tile.
out_row_sel  out  clog2(ARRAY_SIZE)  array row currently driven to GBUFF_OUT.
busy  out  1  high in every state except IDLE and DONE.
done  out  1  job complete; level signal.

Behaviour:
- Reset: state=IDLE; every output 0; all counters and latched dims 0. A reset mid-job aborts the job immediately; no further reads or writes are issued.
- Tile counts: row_tiles=ceil(m/ARRAY_SIZE), col_tiles=ceil(n/ARRAY_SIZE). Both are computed at start, stored in DIM_W bits, and all address arithmetic is done in ADDR_W bits.
- States:
  - IDLE: on start, latch m/k/n. Go to DONE if m, k or n is 0; otherwise zero tile indices and go to CLEAR.
  - CLEAR, 1 cycle: pe_clear=1, then FEED.
  - FEED, k cycles, t=0..k-1: a_rd_en=b_rd_en=1 with the addresses above. feed_valid follows one cycle later (1-cycle buffer read latency).
  - FLUSH, 2*ARRAY_SIZE-1 cycles: no reads. feed_valid=1 only in the first cycle (the last read's data).
  - WRITE, ARRAY_SIZE cycles, j=0..ARRAY_SIZE-1: out_row_sel=j. out_we=1 only when row_tile*ARRAY_SIZE+j < m; out_addr uses row=row_tile*ARRAY_SIZE+j.
  - After the last WRITE cycle: advance col_tile; on wrap, zero it and advance row_tile. If that was the final tile go to DONE, else go to CLEAR.
  - DONE: done=1, held until start; start re-enters the IDLE start handling in the same cycle, and done drops on the next edge.
- Columns beyond n inside the last column tile are still written as whatever the array produces (zero-padded operands); the buffers guarantee zero padding.
- start while busy is ignored; m/k/n changes while busy are ignored.
- Job latency: done rises exactly row_tiles*col_tiles*(k+3*ARRAY_SIZE)+1 cycles after the start sample edge.

Optional Feature:
- TPU_PERF_CNT_EN defined: adds output cycle_cnt [31:0]. It clears on an accepted start, increments every busy cycle, and holds its value in DONE. It also adds out_wr_cnt [15:0], the number of out_we pulses in the job.
- Undefined: neither port exists and there is no counter logic.

Decomposition:
- Shared package / define file (tpu_pkg): ARRAY_SIZE, ADDR_W, DIM_W, state encoding (IDLE, CLEAR, FEED, FLUSH, WRITE, DONE) and a ceil-div function.
- One sub-module, tpu_tile_counter: nested row/column tile counter with wrap and last-tile flag. The FSM and address generation stay in tpu_tile_scheduler.

Test Plan:
- m=k=n=4: reads a_addr/b_addr 0..3; pe_clear at cycle 1; out_we on 4 cycles with out_addr 0..3; done at cycle 17.
- m=6,k=3,n=9: 6 tiles, done at cycle 91. Exactly 18 out_we pulses with addresses 0..17, each exactly once. The row-tile-1 writes cover rows 4..5 only (j=2,3 suppressed).
- m=0 (k=n=4): done at cycle 1 with no a_rd_en, b_rd_en or out_we ever asserted.
- Reset pulse during FEED of tile 2 (m=n=8,k=5): all outputs 0 within the same cycle and state IDLE. A fresh start then reproduces the full-job trace from cycle 0.
- start pulsed while busy, and m changed mid-job: no effect on the addresses or the done timing. A start while in DONE launches a new job and done drops on the next edge.
- With TPU_PERF_CNT_EN and m=k=n=4: cycle_cnt=16 and out_wr_cnt=4 at done.
